// File: rtl/sbit_frame_serializer.sv
// Double-buffers S-bit frame words and shifts them out one byte per VFAT lane per clock8x cycle.
// Frames launch on every byte-counter wrap; gaps are filled with idle frames, counted as underruns when enabled.
module sbit_frame_serializer #(
  parameter int unsigned NUM_VFATS = 24,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                    clock8x,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [64*NUM_VFATS-1:0] sbits_in,
  input  logic                    sbits_valid,
  output logic                    sbits_ready,
  output logic [8*NUM_VFATS-1:0]  vfat_out,
  output logic [2:0]              bytecnt_out,
  output logic                    sof,
  output logic                    frame_valid,
  output logic [15:0]             underrun_cnt
);

  localparam int unsigned FW = 64 * NUM_VFATS;
  localparam int unsigned OW = 8 * NUM_VFATS;

  logic [FW-1:0] r_pending;
  logic [FW-1:0] r_tx;
  logic          r_pend_full;
  logic [2:0]    r_cnt;
  logic          r_sof;
  logic          r_frame_valid;
  logic [15:0]   r_underrun;
  logic [OW-1:0] r_vfat;

  logic          w_launch;
  logic          w_send;
  logic          w_load;
  logic [2:0]    w_nxt_byte;
  logic [FW-1:0] w_tx_next;
  logic [OW-1:0] w_vfat_next;

  assign w_launch   = (r_cnt == 3'd7);
  assign w_send     = w_launch & enable & r_pend_full;
  assign w_load     = sbits_valid & sbits_ready;
  assign w_nxt_byte = r_cnt + 3'd1;

  // Next output byte is picked from the frame that will be held after this edge,
  // so byte 0 of a freshly launched word appears on the cycle right after launch.
  always_comb begin
    w_tx_next = r_tx;
    if (w_launch) begin
      w_tx_next = w_send ? r_pending : {OW{IDLE_BYTE}};
    end
    w_vfat_next = '0;
    for (int k = 0; k < int'(NUM_VFATS); k++) begin
      w_vfat_next[8*k +: 8] = w_tx_next[64*k + 8*int'(w_nxt_byte) +: 8];
    end
  end

  always_ff @(posedge clock8x or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= 3'd7;
      r_pend_full   <= 1'b0;
      r_pending     <= '0;
      r_tx          <= '0;
      r_sof         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_underrun    <= '0;
      r_vfat        <= '0;
    end else begin
      r_cnt  <= r_cnt + 3'd1;
      r_sof  <= w_launch;
      r_vfat <= w_vfat_next;
      r_tx   <= w_tx_next;
      if (w_launch) begin
        r_frame_valid <= w_send;
        if (enable && !r_pend_full && (r_underrun != 16'hFFFF)) begin
          r_underrun <= r_underrun + 16'd1;
        end
      end
      if (w_send) begin
        r_pend_full <= 1'b0;
      end
      // A load can only happen while pending is empty, so it never collides with w_send.
      if (w_load) begin
        r_pending   <= sbits_in;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign sbits_ready  = reset_n & ~r_pend_full;
  assign vfat_out     = r_vfat;
  assign bytecnt_out  = r_cnt;
  assign sof          = r_sof;
  assign frame_valid  = r_frame_valid;
  assign underrun_cnt = r_underrun;

endmodule

// File: doc/sbit_frame_serializer.md
SBIT_FRAME_SERIALIZER -- requirements
Module: sbit_frame_serializer

Interface
REQ-001 SHALL have parameter NUM_VFATS, default 24, number of VFAT byte lanes.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'h00, byte driven on every lane during idle frames.
REQ-003 SHALL have port clock8x, input, 1: single clock for all logic; one byte per lane per cycle.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1: permits launching loaded frames.
REQ-006 SHALL have port sbits_in, input, 64*NUM_VFATS: frame word; VFAT k at [64k+63:64k].
REQ-007 SHALL have port sbits_valid, input, 1: sbits_in holds a frame to load.
REQ-008 SHALL have port sbits_ready, output, 1: pending buffer empty; load accepted on valid&ready.
REQ-009 SHALL have port vfat_out, output, 8*NUM_VFATS: lane k byte at [8k+7:8k].
REQ-010 SHALL have port bytecnt_out, output, 3: index (0..7) of byte currently on vfat_out.
REQ-011 SHALL have port sof, output, 1: high while byte 0 is on vfat_out.
REQ-012 SHALL have port frame_valid, output, 1: current frame carries loaded data (low = idle frame).
REQ-013 SHALL have port underrun_cnt, output, 16: saturating count of idle frames launched while enabled.

Function
REQ-014 SHALL hold one pending-word register and one 64*NUM_VFATS transmit register.
REQ-015 SHALL drive sbits_ready = not pending_full, from flops only (no combinational path from sbits_valid).
REQ-016 SHALL load sbits_in into pending and set pending_full on a clock edge with sbits_valid and sbits_ready high.
REQ-017 SHALL run an internal 3-bit byte counter incrementing every cycle, wrapping 7->0, independent of enable.
REQ-018 SHALL launch a frame on every edge where the counter equals 7.
REQ-019 At launch with enable=1 and pending_full=1: transmit register <= pending, pending_full <= 0, frame_valid <= 1.
REQ-020 At launch otherwise: transmit register <= IDLE_BYTE on all bytes, frame_valid <= 0; pending kept intact.
REQ-021 At launch with enable=1 and pending_full=0: underrun_cnt += 1, saturating at 16'hFFFF.
REQ-022 A load on the launch edge SHALL NOT be transmitted in that launch; it waits for the next launch.
REQ-023 For 8 cycles after launch, vfat_out lane k SHALL present bytes b=0..7 of VFAT k ([64k+8b+7:64k+8b]), LSB byte first, all registered.
REQ-024 bytecnt_out SHALL equal b of the byte on vfat_out; sof SHALL be high exactly when b=0.
REQ-025 frame_valid SHALL stay constant for all 8 bytes of a frame.
REQ-026 Latency: a word loaded while the pending buffer is empty and enable=1 SHALL appear at most 16 cycles later, byte 0 on the cycle after the next launch edge.
REQ-027 sbits_ready SHALL go high on the cycle after the launch that empties pending.

Reset
REQ-028 reset_n low SHALL immediately clear vfat_out, sof, frame_valid, underrun_cnt, and pending_full, and set the counter to 7, independent of clock.
REQ-029 bytecnt_out SHALL read 7 during reset; sbits_ready SHALL be low while reset_n is low and high after release.
REQ-030 The first edge after release SHALL be a launch edge; any frame in progress or pending word at reset SHALL be discarded.

Verification
REQ-031 Reset; enable=1; load vfat0=64'h0807060504030201, others 0, on edge 1 -> edge 1 idle frame, underrun_cnt=1; the frame after edge 9 shows lane0 01..08, sof with 01, and frame_valid high for 8 cycles.
REQ-032 Hold sbits_valid high with words A then B -> A accepted immediately; ready low until A launches; B accepted the cycle after; A and B appear in consecutive frames with no idle frame between them.
REQ-033 enable=1, no loads for 3 launches -> vfat_out=IDLE_BYTE, frame_valid=0, underrun_cnt=3; force 70000 idle launches -> underrun_cnt holds 16'hFFFF.
REQ-034 enable=0 with pending full across 2 launches -> idle frames, underrun_cnt unchanged, ready low; raise enable -> word sent at next launch.
REQ-035 Assert reset_n low while byte 3 of a valid frame is out -> outputs 0 and bytecnt_out=7 at once with no clock; after release, the first frame is idle and the old pending word is never sent.
